// File: rtl/load_store_unit.sv
// load_store_unit
// Sits between the EX stage and the word-wide DataMemory. Byte, half and word
// loads/stores are turned into word accesses. Loads are sign- or zero-extended.
// Sub-word stores are done as read-modify-write. Misaligned, illegal-size and
// out-of-range requests fault without touching memory.
//
// Parameters
//   MEM_WORDS  words in DataMemory; a word index >= MEM_WORDS faults
//   READ_LAT   cycles mem_read is held before mem_read_data is sampled (>= 1)
//
// Ports
//   clock, reset_n          clock (rising edge), async active-low reset
//   req_valid / req_ready   request handshake, accept when both are high
//   req_write, req_size     1=store / 0=load; 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned            loads: 1=zero-extend, 0=sign-extend
//   req_addr, req_wdata     byte address, store data (low bits for sub-word)
//   resp_valid              one-cycle completion pulse
//   resp_rdata, resp_fault  extended load data (0 for stores/faults), fault flag
//   mem_read, mem_write     DataMemory strobes
//   mem_address             word index {2'b00, addr[31:2]}
//   mem_write_data          word to write
//   mem_read_data           DataMemory read data
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; faults go straight to RESP
// RD    | mem_read high for READ_LAT cycles (loads and sub-word stores)
// WR    | mem_write high for one cycle
// RESP  | resp_valid high for one cycle

module load_store_unit #(
    parameter int MEM_WORDS = 32,
    parameter int READ_LAT  = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int          CNT_W       = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               write_q;
    logic [1:0]         size_q;
    logic [1:0]         lane_q;
    logic               unsigned_q;
    logic [31:0]        wdata_q;

    logic               misaligned;
    logic               range_err;
    logic               req_fault;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_ext;
    logic [31:0]        merged;

    assign req_ready  = (state == IDLE);
    assign mem_read   = (state == RD);
    assign mem_write  = (state == WR);
    assign resp_valid = (state == RESP);

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
        range_err = {2'b00, req_addr[31:2]} >= MEM_WORDS_W;
        req_fault = misaligned | range_err;
    end

    // Lane extraction and sign/zero extension of the word coming back from memory.
    always_comb begin
        byte_sel = 8'h00;
        case (lane_q)
            2'd0:    byte_sel = mem_read_data[7:0];
            2'd1:    byte_sel = mem_read_data[15:8];
            2'd2:    byte_sel = mem_read_data[23:16];
            default: byte_sel = mem_read_data[31:24];
        endcase
        half_sel = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_read_data;
        endcase
    end

    // Merge of store data into the old word: only the addressed lane changes.
    always_comb begin
        merged = mem_read_data;
        case (size_q)
            2'b00: begin
                case (lane_q)
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (lane_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            write_q        <= 1'b0;
            size_q         <= 2'b00;
            lane_q         <= 2'b00;
            unsigned_q     <= 1'b0;
            wdata_q        <= 32'h0;
            resp_rdata     <= 32'h0;
            resp_fault     <= 1'b0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q        <= req_write;
                        size_q         <= req_size;
                        lane_q         <= req_addr[1:0];
                        unsigned_q     <= req_unsigned;
                        wdata_q        <= req_wdata;
                        mem_address    <= {2'b00, req_addr[31:2]};
                        resp_rdata     <= 32'h0;
                        resp_fault     <= 1'b0;
                        mem_write_data <= 32'h0;
                        if (req_fault) begin
                            resp_fault <= 1'b1;
                            state      <= RESP;
                        end else if (req_write && req_size == 2'b10) begin
                            mem_write_data <= req_wdata;
                            state          <= WR;
                        end else begin
                            // Loads and sub-word stores both need the old word first.
                            cnt   <= CNT_W'(READ_LAT - 1);
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        if (write_q) begin
                            mem_write_data <= merged;
                            state          <= WR;
                        end else begin
                            resp_rdata <= load_ext;
                            state      <= RESP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR:      state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed bench for load_store_unit with a word-array DataMemory model.
// Ports of the DUT are all driven/observed here; expected values are hand-computed.

module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [32];
    int          n_vec = 0;
    int          n_err = 0;
    int          wr_count = 0;
    int          acc_cnt = 0;
    logic        acc_write [$];

    always #5 clock = ~clock;

    load_store_unit #(.MEM_WORDS(32), .READ_LAT(2)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[4:0]];

    always @(posedge clock) begin
        if (mem_write) begin
            mem[mem_address[4:0]] <= mem_write_data;
            wr_count <= wr_count + 1;
        end
        if (req_valid && req_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_write.push_back(req_write);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_f, input int exp_lat);
        int          lat;
        logic        got;
        logic        saw_rd;
        logic        saw_wr;
        logic [31:0] wr_addr;
        logic [31:0] rd;
        logic        f;
        lat = 0; got = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0;
        wr_addr = 32'h0; rd = 32'h0; f = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clock);
        while (!got && lat < 20) begin
            @(negedge clock);
            if (lat == 0) req_valid = 1'b0;
            lat++;
            if (mem_read) saw_rd = 1'b1;
            if (mem_write) begin
                saw_wr  = 1'b1;
                wr_addr = mem_address;
            end
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                f   = resp_fault;
            end
        end
        check({tag, "_resp_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_fault"}, 32'(f), 32'(exp_f));
        check({tag, "_mem_read"}, 32'(saw_rd), 32'(!exp_f && (!w || sz != 2'b10)));
        check({tag, "_mem_write"}, 32'(saw_wr), 32'(!exp_f && w));
        if (!exp_f && w) check({tag, "_wr_addr"}, wr_addr, {2'b00, a[31:2]});
        @(negedge clock);
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int   n;
        int   wc;
        logic got;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_fault", 32'(resp_fault), 32'd0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // 1: word store then load
        do_req("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check("word4_sw", mem[4], 32'hDEADBEEF);
        do_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

        // 2: byte store, signed/unsigned byte loads
        do_req("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 32'h0, 1'b0, 4);
        check("word4_sb", mem[4], 32'hDEADAAEF);
        do_req("lb_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 3);
        do_req("lbu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0, 3);

        // 3: half store, half loads
        do_req("sh_12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 32'h0, 1'b0, 4);
        check("word4_sh", mem[4], 32'h1234AAEF);
        do_req("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00001234, 1'b0, 3);
        do_req("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000AAEF, 1'b0, 3);
        do_req("lh_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFAAEF, 1'b0, 3);
        do_req("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000012, 1'b0, 3);

        // last legal word
        do_req("sw_7c", 1'b1, 2'b10, 1'b0, 32'h7C, 32'h80000001, 32'h0, 1'b0, 2);
        do_req("lw_7c", 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 32'h80000001, 1'b0, 3);

        // 4: faults
        wc = wr_count;
        do_req("lw_13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1);
        do_req("sh_11", 1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 32'h0, 1'b1, 1);
        do_req("size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        do_req("lw_80", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 1);
        do_req("sw_80", 1'b1, 2'b10, 1'b0, 32'h80, 32'h1, 32'h0, 1'b1, 1);
        check("fault_no_writes", 32'(wr_count), 32'(wc));
        check("word4_after_faults", mem[4], 32'h1234AAEF);

        // 5: reset during RD of a sub-word store
        wc = wr_count;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h00000055;
        @(posedge clock);
        #2;
        req_valid = 1'b0;
        check("rmw_in_rd", 32'(mem_read), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("midrst_resp", {30'd0, resp_valid, resp_fault}, 32'd0);
        check("midrst_rdata", resp_rdata, 32'h0);
        check("midrst_mem_addr", mem_address, 32'h0);
        check("midrst_mem_wdata", mem_write_data, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("midrst_word4", mem[4], 32'h1234AAEF);
        check("midrst_no_write", 32'(wr_count), 32'(wc));

        // 6: req_valid held across back-to-back sw / lw
        acc_cnt = 0;
        acc_write.delete();
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        @(posedge clock);
        @(negedge clock);
        check("b2b_acc1", 32'(acc_cnt), 32'd1);
        check("b2b_busy_ready", 32'(req_ready), 32'd0);
        req_write = 1'b0; req_wdata = 32'h0;
        n = 0;
        while (acc_cnt < 2 && n < 20) begin
            if (resp_valid) check("b2b_resp_ready", 32'(req_ready), 32'd0);
            @(negedge clock);
            n++;
        end
        req_valid = 1'b0;
        check("b2b_acc2", 32'(acc_cnt), 32'd2);
        check("b2b_busy_ready2", 32'(req_ready), 32'd0);
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            if (resp_valid) begin
                got = 1'b1;
                check("b2b_lw_rdata", resp_rdata, 32'hCAFEF00D);
                check("b2b_lw_fault", 32'(resp_fault), 32'd0);
            end else begin
                @(negedge clock);
                n++;
            end
        end
        check("b2b_lw_seen", 32'(got), 32'd1);
        repeat (4) @(negedge clock);
        check("b2b_acc_total", 32'(acc_cnt), 32'd2);
        check("b2b_order", {30'd0, acc_write[0], acc_write[1]}, 32'b10);
        check("word8", mem[8], 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
